mem_fpu_seq: RTL

Operand sequencer sitting directly downstream of the memory controller. Once the controller has filled the operand RAM, this block reads consecutive word pairs (opa, opb) from RAM and issues each pair to the FPU with a start/ready handshake. It then streams each FPU result out over a valid/ready interface and pulses done when the programmed number of words has been consumed.

---
 rtl/mem_fpu_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_fpu_seq.sv
// rtl/mem_fpu_seq.sv - operand sequencer: RAM word pairs -> FPU -> result stream
module mem_fpu_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic              seq_start,
  input  logic [ADDR_W-1:0] seq_length,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] fpu_opa,
  output logic [DATA_W-1:0] fpu_opb,
  output logic              fpu_start,
  input  logic              fpu_ready,
  input  logic [DATA_W-1:0] fpu_result,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CAP_B, FPU_GO, FPU_WAIT, OUT, DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] pairs;

  // Outputs are registered, so each read address is driven on entry to the
  // state that owns it; ptr always holds the next address to issue.
  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) begin
      state     <= IDLE;
      ptr       <= '0;
      pairs     <= '0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
      seq_err   <= 1'b0;
      ram_addr  <= '0;
      ram_rd    <= 1'b0;
      fpu_opa   <= '0;
      fpu_opb   <= '0;
      fpu_start <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      seq_err   <= 1'b0;
      seq_done  <= 1'b0;
      fpu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (seq_start) begin
            if (seq_length[0]) begin
              seq_err <= 1'b1;
            end else if (seq_length == '0) begin
              seq_busy <= 1'b1;
              seq_done <= 1'b1;
              state    <= DONE;
            end else begin
              seq_busy <= 1'b1;
              pairs    <= seq_length >> 1;
              ram_addr <= '0;
              ptr      <= ADDR_W'(1);
              ram_rd   <= 1'b1;
              state    <= RD_A;
            end
          end
        end
        RD_A: begin
          ram_addr <= ptr;
          ptr      <= ptr + 1'b1;
          state    <= RD_B;
        end
        RD_B: begin
          ram_rd  <= 1'b0;
          fpu_opa <= ram_data;
          state   <= CAP_B;
        end
        CAP_B: begin
          fpu_opb   <= ram_data;
          fpu_start <= 1'b1;
          state     <= FPU_GO;
        end
        FPU_GO: state <= FPU_WAIT;
        FPU_WAIT: begin
          if (fpu_ready) begin
            res_data  <= fpu_result;
            res_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            pairs     <= pairs - 1'b1;
            if (pairs == ADDR_W'(1)) begin
              seq_done <= 1'b1;
              state    <= DONE;
            end else begin
              ram_addr <= ptr;
              ptr      <= ptr + 1'b1;
              ram_rd   <= 1'b1;
              state    <= RD_A;
            end
          end
        end
        DONE: begin
          seq_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
